// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream cipher: FSM states and array sizes.
package rc4_pkg;
  localparam int KEY_LEN   = 16;
  localparam int SBOX_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    KSA_J,
    KSA_SWAP,
    PRGA_I,
    PRGA_SWAP,
    PRGA_OUT,
    WAIT
  } rc4_state_t;
endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation store: 256x8 registers, two combinational read ports,
// a single-entry fill port and a two-address swap port.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] rd_addr_a,
  output logic [7:0] rd_data_a,
  input  logic [7:0] rd_addr_b,
  output logic [7:0] rd_data_b,
  input  logic       fill_en,
  input  logic [7:0] fill_addr,
  input  logic [7:0] fill_data,
  input  logic       swap_en,
  input  logic [7:0] swap_addr_a,
  input  logic [7:0] swap_addr_b
);

  logic [7:0] mem [SBOX_SIZE];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // Contents are defined by FILL, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_addr] <= fill_data;
    end else if (swap_en && (swap_addr_a != swap_addr_b)) begin
      mem[swap_addr_a] <= mem[swap_addr_b];
      mem[swap_addr_b] <= mem[swap_addr_a];
    end
  end

endmodule

// File: rtl/rc4_encryption.sv
// RC4 stream cipher: key setup (fill + KSA) followed by a PRGA that XORs one
// keystream byte into each accepted plaintext byte over valid/ready handshakes.
module rc4_encryption
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = rc4_pkg::KEY_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed [KEY_LEN],
  input  logic       key_load,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       init_done
);

  rc4_state_t state, next_state;

  logic [7:0] key [KEY_LEN];
  logic [7:0] i, j, k;
  logic [7:0] t;
  logic [7:0] ks;
  logic       ks_valid;
  logic [7:0] jn;
  logic       accept;

  logic [7:0] rd_addr_a, rd_data_a, rd_addr_b, rd_data_b;
  logic       fill_en, swap_en;
  logic [7:0] swap_addr_b;

  assign din_ready = ks_valid && (!dout_valid || dout_ready);
  assign accept    = din_valid && din_ready;

  // Port A serves S[i] everywhere except PRGA_OUT, where it fetches S[t].
  // Port B chains off port A so PRGA_SWAP sees S[j + S[i]] in the same cycle.
  assign rd_addr_a   = (state == PRGA_OUT) ? t : i;
  assign jn          = j + rd_data_a;
  assign rd_addr_b   = jn;
  assign fill_en     = (state == FILL);
  assign swap_en     = (state == KSA_SWAP) || (state == PRGA_SWAP);
  assign swap_addr_b = (state == PRGA_SWAP) ? jn : j;

  rc4_sbox u_sbox (
    .clk         (clk),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .fill_en     (fill_en),
    .fill_addr   (k),
    .fill_data   (k),
    .swap_en     (swap_en),
    .swap_addr_a (i),
    .swap_addr_b (swap_addr_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A key_load from any state restarts key setup.
  always_comb begin
    next_state = state;
    if (key_load) begin
      next_state = FILL;
    end else begin
      case (state)
        IDLE:      next_state = IDLE;
        FILL:      if (k == 8'd255) next_state = KSA_J;
        KSA_J:     next_state = KSA_SWAP;
        KSA_SWAP:  next_state = (i == 8'd255) ? PRGA_I : KSA_J;
        PRGA_I:    next_state = PRGA_SWAP;
        PRGA_SWAP: next_state = PRGA_OUT;
        PRGA_OUT:  next_state = WAIT;
        WAIT:      if (accept) next_state = PRGA_I;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (key_load) key <= seed;
  end

  // The post-swap sum S[i]+S[j] equals the pre-swap S[i]+S[jn], so it is
  // captured in PRGA_SWAP as t and looked up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i          <= 8'h00;
      j          <= 8'h00;
      k          <= 8'h00;
      t          <= 8'h00;
      ks         <= 8'h00;
      ks_valid   <= 1'b0;
      init_done  <= 1'b0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else if (key_load) begin
      i          <= 8'h00;
      j          <= 8'h00;
      k          <= 8'h00;
      ks_valid   <= 1'b0;
      init_done  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          k <= k + 8'd1;
          if (k == 8'd255) begin
            i <= 8'h00;
            j <= 8'h00;
          end
        end
        KSA_J:    j <= j + rd_data_a + key[i[3:0]];
        KSA_SWAP: begin
          if (i == 8'd255) begin
            i         <= 8'h00;
            j         <= 8'h00;
            init_done <= 1'b1;
          end else begin
            i <= i + 8'd1;
          end
        end
        PRGA_I:    i <= i + 8'd1;
        PRGA_SWAP: begin
          j <= jn;
          t <= rd_data_a + rd_data_b;
        end
        PRGA_OUT: begin
          ks       <= rd_data_a;
          ks_valid <= 1'b1;
        end
        default: ;
      endcase

      if (accept) begin
        dout       <= din ^ ks;
        dout_valid <= 1'b1;
        ks_valid   <= 1'b0;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
